// File: rtl/winograd_pkg.sv
// Shared constants and types for the Winograd output-tile assembler.
package winograd_pkg;

   localparam int TILE_DIM           = 4;
   localparam int GRID_DIM           = 3;
   localparam int IMG_ROWS           = 8;
   localparam int IMG_COLS           = 10;
   localparam int DEFAULT_DATA_WIDTH = 16;

   // Only grid rows 0 and 1 land inside the 8-row image, so only they are buffered.
   localparam int BUF_ROWS           = 2;
   localparam int NUM_TILES          = GRID_DIM * GRID_DIM;

   typedef enum logic {
      COLLECT,
      EMIT
   } asm_state_t;

endpackage

// File: rtl/winograd_row_select.sv
// Stitch/clip mapping: picks one 10-element image row out of the tile buffer.
module winograd_row_select
   import winograd_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic [0:BUF_ROWS-1][0:GRID_DIM-1][0:TILE_DIM-1][0:TILE_DIM-1][DATA_WIDTH-1:0] i_buf,
   input  logic [2:0]                                                                   i_row_idx,
   output logic [0:IMG_COLS-1][DATA_WIDTH-1:0]                                          o_row
);

   logic       w_gr;
   logic [1:0] w_r;

   // Image row i lives in grid row i/4, tile row i%4.
   assign w_gr = i_row_idx[2];
   assign w_r  = i_row_idx[1:0];

   // Column j comes from grid column j/4, tile column j%4; columns 10 and 11 simply do not exist.
   genvar gi;
   generate
      for (gi = 0; gi < IMG_COLS; gi++) begin : g_col
         assign o_row[gi] = i_buf[w_gr][gi / TILE_DIM][w_r][gi % TILE_DIM];
      end
   endgenerate

endmodule

// File: rtl/winograd_tile_assembler.sv
// Collects a 3x3 grid of 4x4 tiles, keeps the six that cover the 8x10 image,
// then streams the image out one row per handshake.
module winograd_tile_assembler
   import winograd_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                                             clk,
   input  logic                                             rst_n,
   input  logic                                             flush,
   input  logic                                             in_valid,
   output logic                                             in_ready,
   input  logic [0:TILE_DIM-1][0:TILE_DIM-1][DATA_WIDTH-1:0] in_tile,
   output logic                                             out_valid,
   input  logic                                             out_ready,
   output logic [0:IMG_COLS-1][DATA_WIDTH-1:0]              out_row,
   output logic [2:0]                                       out_row_idx,
   output logic                                             out_last,
   output logic                                             frame_done
);

   localparam logic [3:0] TILE_LAST = 4'(NUM_TILES - 1);
   localparam logic [2:0] ROW_LAST  = 3'(IMG_ROWS - 1);

   typedef logic [0:TILE_DIM-1][0:TILE_DIM-1][DATA_WIDTH-1:0] tile_t;

   asm_state_t r_state;
   asm_state_t w_state_next;
   logic [3:0] r_tile_cnt;
   logic [3:0] w_tile_cnt_next;
   logic [2:0] r_row_cnt;
   logic [2:0] w_row_cnt_next;
   logic       r_frame_done;
   logic       w_frame_done_next;
   logic       w_accept;

   tile_t [0:BUF_ROWS-1][0:GRID_DIM-1] w_buf;

   // A flushed handshake never writes the buffer.
   assign w_accept = in_valid && in_ready && !flush;

   // One register slot per buffered tile; slot index equals the raster tile count.
   genvar gi;
   generate
      for (gi = 0; gi < BUF_ROWS * GRID_DIM; gi++) begin : g_buf
         tile_t r_tile;

         // Capture the incoming tile when the raster counter points at this slot.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_tile <= '0;
            end else if (w_accept && (r_tile_cnt == 4'(gi))) begin
               r_tile <= in_tile;
            end
         end

         assign w_buf[gi / GRID_DIM][gi % GRID_DIM] = r_tile;
      end
   endgenerate

   // State, counters and the registered end-of-frame pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= COLLECT;
         r_tile_cnt   <= '0;
         r_row_cnt    <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_tile_cnt   <= w_tile_cnt_next;
         r_row_cnt    <= w_row_cnt_next;
         r_frame_done <= w_frame_done_next;
      end
   end

   // Next-state logic and handshake outputs; flush overrides any handshake.
   always_comb begin
      w_state_next      = r_state;
      w_tile_cnt_next   = r_tile_cnt;
      w_row_cnt_next    = r_row_cnt;
      w_frame_done_next = 1'b0;
      in_ready          = (r_state == COLLECT);
      out_valid         = (r_state == EMIT);

      if (flush) begin
         w_state_next    = COLLECT;
         w_tile_cnt_next = '0;
         w_row_cnt_next  = '0;
      end else begin
         case (r_state)
            COLLECT: begin
               if (in_valid) begin
                  if (r_tile_cnt == TILE_LAST) begin
                     w_state_next    = EMIT;
                     w_tile_cnt_next = '0;
                     w_row_cnt_next  = '0;
                  end else begin
                     w_tile_cnt_next = r_tile_cnt + 4'd1;
                  end
               end
            end
            EMIT: begin
               if (out_ready) begin
                  if (r_row_cnt == ROW_LAST) begin
                     w_state_next      = COLLECT;
                     w_row_cnt_next    = '0;
                     w_frame_done_next = 1'b1;
                  end else begin
                     w_row_cnt_next = r_row_cnt + 3'd1;
                  end
               end
            end
            default: begin
               w_state_next = COLLECT;
            end
         endcase
      end
   end

   // row_cnt rests at 0 outside EMIT, so these read 0 whenever no row is presented.
   assign out_row_idx = r_row_cnt;
   assign out_last    = (r_row_cnt == ROW_LAST);
   assign frame_done  = r_frame_done;

   winograd_row_select #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_row_select (
      .i_buf     (w_buf),
      .i_row_idx (r_row_cnt),
      .o_row     (out_row)
   );

endmodule

// File: tb/tb_winograd_tile_assembler.sv
// Scoreboard bench for winograd_tile_assembler: expected image rows are queued
// when a frame is driven and popped as the DUT hands rows out.
module tb_winograd_tile_assembler;
   import winograd_pkg::*;

   localparam int DW = 16;

   typedef logic [0:3][0:3][DW-1:0] tile_t;
   typedef logic [0:9][DW-1:0]      row_t;
   typedef struct {
      row_t       row;
      logic [2:0] idx;
      logic       last;
   } exp_row_t;

   logic       clk;
   logic       rst_n;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   tile_t      in_tile;
   logic       out_valid;
   logic       out_ready;
   row_t       out_row;
   logic [2:0] out_row_idx;
   logic       out_last;
   logic       frame_done;

   exp_row_t   sb_q[$];
   exp_row_t   mon_e;
   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   int         done_cnt = 0;
   int         done_cyc = -1;
   int         acc_cnt  = 0;
   bit         ffff_mode = 0;
   bit         hold_pend = 0;
   row_t       hold_row;
   logic [2:0] hold_idx;

   winograd_tile_assembler #(.DATA_WIDTH(DW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_tile     (in_tile),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_row     (out_row),
      .out_row_idx (out_row_idx),
      .out_last    (out_last),
      .frame_done  (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_value(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] tile_val(int off, int k, int r, int c, bit ffff_tail);
      if (ffff_tail && k >= 6) return 16'hFFFF;
      return DW'(off + k * 16 + r * 4 + c);
   endfunction

   // Expected image: element (i,j) comes from tile (i/4)*3 + j/4, element [i%4][j%4].
   task automatic push_frame(input int off, input bit ffff_tail);
      exp_row_t e;
      row_t     rw;
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 10; j++)
            rw[j] = tile_val(off, (i / 4) * 3 + j / 4, i % 4, j % 4, ffff_tail);
         e.row  = rw;
         e.idx  = 3'(i);
         e.last = (i == 7);
         sb_q.push_back(e);
      end
   endtask

   task automatic send_tile(input tile_t t, output int hs_cyc);
      bit got;
      got      = 0;
      hs_cyc   = -1;
      in_tile  = t;
      in_valid = 1'b1;
      for (int w = 0; w < 60; w++) begin
         @(negedge clk);
         if (in_ready && rst_n) begin
            got    = 1;
            hs_cyc = cyc;
         end
         @(posedge clk);
         #1;
         if (got) break;
      end
      if (!got) check_value("tile_timeout", 0, 1);
   endtask

   task automatic send_frame(input int off, input bit ffff_tail, input bit toggle,
                             input int ntiles, output int first_cyc);
      tile_t t;
      int    hc;
      first_cyc = -1;
      for (int k = 0; k < ntiles; k++) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               t[r][c] = tile_val(off, k, r, c, ffff_tail);
         send_tile(t, hc);
         if (k == 0) first_cyc = hc;
         if (toggle && k < ntiles - 1) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      bit ok;
      ok = 0;
      for (int w = 0; w < 200; w++) begin
         @(negedge clk);
         if (sb_q.size() == 0 && !out_valid) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check_value("drain_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   // Output monitor: row scoreboard, stall stability, EMIT input blocking, frame_done log.
   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (in_valid && in_ready && !flush) acc_cnt++;
         if (hold_pend && out_valid) begin
            check_value("hold_row", out_row, hold_row);
            check_value("hold_idx", out_row_idx, hold_idx);
         end
         hold_pend = 0;
         if (out_valid) begin
            check_value("in_ready_emit", in_ready, 0);
            if (!out_ready) begin
               hold_pend = 1;
               hold_row  = out_row;
               hold_idx  = out_row_idx;
            end else if (!flush) begin
               if (sb_q.size() == 0) begin
                  check_value("unexpected_row", out_row_idx, 3'h0 - 3'h1);
               end else begin
                  mon_e = sb_q.pop_front();
                  check_value("row_data", out_row, mon_e.row);
                  check_value("row_idx", out_row_idx, mon_e.idx);
                  check_value("row_last", out_last, mon_e.last);
                  if (ffff_mode) begin
                     bit has_ffff;
                     has_ffff = 0;
                     for (int j = 0; j < 10; j++)
                        if (out_row[j] == 16'hFFFF) has_ffff = 1;
                     $display("row %0d checked (no-FFFF scan=%0d)", mon_e.idx, has_ffff);
                     check_value("no_ffff", has_ffff, 0);
                  end else begin
                     $display("row %0d checked", mon_e.idx);
                  end
               end
            end
         end
      end
   end

   initial begin
      int  c0;
      int  d0;
      int  a0;
      bit  seen;
      tile_t junk;

      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_tile   = '0;
      out_ready = 1'b1;

      // Reset state
      #2;
      check_value("rst_in_ready", in_ready, 1);
      check_value("rst_out_valid", out_valid, 0);
      check_value("rst_out_row", out_row, 0);
      check_value("rst_row_idx", out_row_idx, 0);
      check_value("rst_out_last", out_last, 0);
      check_value("rst_frame_done", frame_done, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic frame and frame_done timing
      d0 = done_cnt;
      push_frame(0, 0);
      send_frame(0, 0, 0, 9, c0);
      wait_drain();
      check_value("basic_done_cnt", done_cnt - d0, 1);
      check_value("basic_done_cyc", done_cyc - c0, 17);

      // Clipped tiles full of 0xFFFF must not change the image
      ffff_mode = 1;
      push_frame(0, 1);
      send_frame(0, 1, 0, 9, c0);
      wait_drain();
      ffff_mode = 0;

      // Backpressure at row 2
      push_frame(32, 0);
      send_frame(32, 0, 0, 9, c0);
      seen = 0;
      for (int w = 0; w < 40; w++) begin
         if (out_valid && out_row_idx == 3'd2) begin
            seen = 1;
            out_ready = 1'b0;
            repeat (3) begin @(posedge clk); #1; end
            out_ready = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      check_value("bp_reached_row2", seen, 1);
      wait_drain();

      // in_valid toggling in COLLECT, in_valid held high through EMIT
      a0 = acc_cnt;
      push_frame(64, 0);
      send_frame(64, 0, 1, 9, c0);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            junk[r][c] = 16'hBEEF;
      in_tile  = junk;
      in_valid = 1'b1;
      repeat (8) begin @(posedge clk); #1; end
      in_valid = 1'b0;
      wait_drain();
      check_value("toggle_accepted", acc_cnt - a0, 9);

      // Flush on the 5th tile handshake, then a clean frame
      d0 = done_cnt;
      send_frame(16'h500, 0, 0, 4, c0);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            junk[r][c] = tile_val(16'h500, 4, r, c, 0);
      in_tile  = junk;
      in_valid = 1'b1;
      flush    = 1'b1;
      @(posedge clk); #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      push_frame(16'h100, 0);
      send_frame(16'h100, 0, 0, 9, c0);
      wait_drain();
      check_value("flush_done_cnt", done_cnt - d0, 1);

      // Asynchronous reset during row 4 of EMIT
      push_frame(16'h200, 0);
      send_frame(16'h200, 0, 0, 9, c0);
      seen = 0;
      for (int w = 0; w < 40; w++) begin
         if (out_valid && out_row_idx == 3'd4) begin
            seen = 1;
            break;
         end
         @(posedge clk); #1;
      end
      check_value("rst_reached_row4", seen, 1);
      d0 = done_cnt;
      rst_n = 1'b0;
      #1;
      check_value("mid_rst_out_valid", out_valid, 0);
      check_value("mid_rst_in_ready", in_ready, 1);
      check_value("mid_rst_row_idx", out_row_idx, 0);
      check_value("mid_rst_frame_done", frame_done, 0);
      sb_q.delete();
      hold_pend = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      check_value("mid_rst_no_done", done_cnt - d0, 0);
      push_frame(16'h300, 0);
      send_frame(16'h300, 0, 0, 9, c0);
      wait_drain();
      check_value("post_rst_done_cnt", done_cnt - d0, 1);

      check_value("sb_empty", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/winograd_tile_assembler.md
# winograd_tile_assembler

Controller that sequences Winograd output-tile stitching. It collects a 3x3 grid of 4x4 output tiles from the inverse-transform stage over a valid/ready stream and buffers the six tiles that land inside the 8x10 output image. Tile-grid row 2 and tile-grid column 2, tile columns 2..3 are clipped. It then streams the assembled image out one 10-element row per handshake. It sits between the Winograd inverse transform and the result writeback.

## Interface
Parameters:
- DATA_WIDTH, 16, element width in bits.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort; drops the current frame.
- in_valid  input  1  tile present.
- in_ready  output  1  assembler can accept a tile.
- in_tile  input  [0:3][0:3] x DATA_WIDTH  4x4 tile, indexed [row][col].
- out_valid  output  1  image row present.
- out_ready  input  1  downstream accepts the row.
- out_row  output  [0:9] x DATA_WIDTH  one image row.
- out_row_idx  output  3  image row index 0..7.
- out_last  output  1  high with row 7.
- frame_done  output  1  one-cycle pulse after row 7 is accepted.

## Operation
- States: COLLECT, EMIT. Reset state is COLLECT.
- COLLECT:
  - in_ready=1 and out_valid=0.
  - tile_cnt (4 bits, 0..8) counts accepted tiles in raster order: grid row gr = tile_cnt/3, grid col gc = tile_cnt%3.
  - On in_valid && in_ready, if gr<2 store in_tile into buf[gr][gc]. Tiles with gr=2 are handshaken and discarded.
  - Tile 8 accepted -> EMIT, tile_cnt=0, row_cnt=0.
- EMIT:
  - in_ready=0 and out_valid=1.
  - For image row i (i=row_cnt): gr=i/4, r=i%4.
  - out_row[0:3] = buf[gr][0][r][0:3].
  - out_row[4:7] = buf[gr][1][r][0:3].
  - out_row[8:9] = buf[gr][2][r][0:1].
  - Columns 2..3 of grid column 2 are never output.
  - out_row_idx=row_cnt, out_last=(row_cnt==7).
  - On out_valid && out_ready: row_cnt+1. When row 7 is accepted: -> COLLECT, frame_done=1 next cycle.
- flush:
  - In either state, the next state is COLLECT with tile_cnt=0 and row_cnt=0. Buffer contents are kept but are stale.
  - flush has priority over a coincident in/out handshake; that handshake is ignored and no frame_done is produced.
- No input data is accepted while in EMIT. Back-to-back frames therefore alternate COLLECT (9 tile cycles minimum) and EMIT (8 row cycles minimum).

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_row_idx=0, out_last=0, frame_done=0.
  - State COLLECT, tile_cnt=0, row_cnt=0, all buf registers 0, so out_row=0.
- out_row, out_row_idx and out_last are combinational from registered buf, state and row_cnt.
- Latency: out_valid rises in the cycle after the 9th tile handshake. Minimum frame time is 17 cycles at full throughput.
- While out_valid && !out_ready, out_row, out_row_idx and out_last stay stable.
- frame_done is registered: high exactly one cycle, in the cycle after the row-7 handshake, coincident with in_ready returning to 1.
- Reset asserted mid-EMIT or mid-COLLECT: the output values above apply immediately (asynchronous) and the partial frame is lost.

## Structure
- Shared package winograd_pkg:
  - TILE_DIM=4, GRID_DIM=3, IMG_ROWS=8, IMG_COLS=10.
  - Default DATA_WIDTH.
  - typedef enum logic {COLLECT, EMIT} asm_state_t.
- One natural sub-module, winograd_row_select: combinational; buf plus row index in, 10-element clipped row out. It isolates the stitch/clip mapping from the FSM.
- FSM, counters and buffer stay in the top level.

## Test plan
Stimulus convention: tile k (raster 0..8) element [r][c] = k*16 + r*4 + c. out_ready tied to 1 unless noted.
- Basic frame -> required rows:
  - Row 0 = 0,1,2,3,16,17,18,19,32,33.
  - Row 5 = 52,53,54,55,68,69,70,71,84,85.
  - Row 7 = 60..63,76..79,92,93, with out_last=1.
  - frame_done pulses once, in cycle 18 after the first tile handshake.
- Tiles 6..8 all elements 0xFFFF -> image identical to the basic frame. Value 0xFFFF never appears on out_row.
- Backpressure: out_ready low for 3 cycles at row 2 -> out_row and out_row_idx=2 are held unchanged. No row is skipped or duplicated, and all 8 rows still arrive in order.
- in_valid toggling 1/0 during COLLECT -> exactly 9 tiles are accepted. in_ready=0 for all 8 EMIT cycles, and no tile is absorbed during EMIT.
- flush asserted on the 5th tile handshake -> that tile is ignored and tile_cnt=0. A following full 9-tile frame yields the correct image with no frame_done from the aborted frame.
- rst_n pulsed low during row 4 of EMIT -> out_valid=0 and in_ready=1 immediately, no frame_done. The next full frame assembles correctly.
